// File: rtl/spi_slave_target.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_target                                             |
// | Description : SPI target endpoint. SCLK/CS/MOSI are oversampled in the     |
// |               clk_i domain (never used as clocks). Samples MOSI on SCLK    |
// |               rise, shifts MISO on SCLK fall (SPI modes 0 and 3), MSB      |
// |               first. Byte-wide valid/ready RX and one-entry TX buffer.     |
// | Ports       : clk_i/rst_i      system clock, sync active-high reset        |
// |               sclk_i/cs_i/mosi_i  async SPI inputs (cs active-high)        |
// |               miso_o/miso_oe_o    serial out and its enable                |
// |               rx_*                received word, valid/ready, overrun      |
// |               tx_*                word to send, valid/ready, underrun      |
// |               frame_active_o/frame_abort_o  frame status                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_target #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] TX_IDLE_BYTE = '1,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              frame_active_o,
  output logic              frame_abort_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] c_bit_top = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Synchronizers plus one delay flop for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_overrun_q, rx_overrun_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic                miso_q, miso_d;
  logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
  logic                tx_full_q, tx_full_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                idle_pend_q, idle_pend_d;
  logic                seen_rise_q, seen_rise_d;
  logic                frame_abort_q, frame_abort_d;

  logic             sclk_s, cs_s, mosi_s;
  logic             sclk_rise, sclk_fall, cs_rise;
  logic             load;
  logic [CNT_W-1:0] bit_idx;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  // After k rises of the current word, the next fall presents bit DATA_W-1-k;
  // at k=0 (just past a boundary) that is the MSB of the freshly loaded word.
  assign bit_idx   = c_bit_top - bit_cnt_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_underrun_d = 1'b0;
    idle_pend_d   = idle_pend_q;
    seen_rise_d   = seen_rise_q;
    frame_abort_d = 1'b0;
    load          = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!cs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
          load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!cs_s) begin
          state_d       = ST_IDLE;
          frame_abort_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          seen_rise_d = 1'b1;
          rx_shift_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
          // An idle-byte word is reported when it actually starts on the wire,
          // so the trailing boundary load at the end of a frame stays silent.
          if (bit_cnt_q == '0 && idle_pend_q) begin
            tx_underrun_d = 1'b1;
            idle_pend_d   = 1'b0;
          end
          if (bit_cnt_q == c_bit_top) begin
            bit_cnt_d    = '0;
            rx_data_d    = rx_shift_d;
            rx_valid_d   = 1'b1;
            rx_overrun_d = rx_valid_q & ~rx_ready_i;
            load         = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && seen_rise_q) begin
          miso_d = tx_shift_q[bit_idx];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving the frame discards the partial word and the shifting TX word;
    // the TX buffer is deliberately kept.
    if (state_q != ST_IDLE && state_d == ST_IDLE) begin
      bit_cnt_d   = '0;
      seen_rise_d = 1'b0;
      idle_pend_d = 1'b0;
      tx_shift_d  = '0;
      miso_d      = 1'b0;
    end

    if (load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d  = TX_IDLE_BYTE;
        idle_pend_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end

    // Accept uses the pre-load buffer state, so a same-cycle offer never
    // feeds the load above; it waits for the next boundary.
    if (tx_valid_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '0;
      mosi_sync_q   <= '0;
      sclk_dly_q    <= 1'b0;
      cs_dly_q      <= 1'b0;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_shift_q    <= '0;
      miso_q        <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      idle_pend_q   <= 1'b0;
      seen_rise_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_dly_q    <= sclk_s;
      cs_dly_q      <= cs_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_shift_q    <= tx_shift_d;
      miso_q        <= miso_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_underrun_q <= tx_underrun_d;
      idle_pend_q   <= idle_pend_d;
      seen_rise_q   <= seen_rise_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso_o         = (state_q != ST_IDLE) & miso_q;
  assign miso_oe_o      = (state_q != ST_IDLE);
  assign frame_active_o = (state_q != ST_IDLE);
  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = rx_overrun_q;
  assign tx_ready_o     = ~tx_full_q;
  assign tx_underrun_o  = tx_underrun_q;
  assign frame_abort_o  = frame_abort_q;

endmodule
`default_nettype wire
